// File: rtl/rf_wb_scoreboard.sv
// rf_wb_scoreboard
//   Write-port arbiter and hazard scoreboard for a 32x32 register file with a
//   single synchronous write port. The pipeline writeback path always wins the
//   port; the long-latency unit (load/MDU) gets it through a valid/ready
//   handshake whenever the pipeline is not writing. Registers with outstanding
//   long-unit writes are tracked in a pending vector, and issue is stalled on
//   RAW/WAW hazards, on outstanding-limit overflow, and while a drain is forced
//   because the long unit has been starved of the port for too long.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   iss_valid/rs1/rs2/rd/long   instruction at issue; iss_stall blocks it
//   wb_valid/rd/data     pipeline writeback (never back-pressured)
//   lu_valid/rd/data     long-unit result; lu_ready accepts it
//   rf_we/rf_wR/rf_wD    register-file write port
//   sb_pending           bit i set while xi has an outstanding long-unit write
module rf_wb_scoreboard #(
   parameter int unsigned MAX_OUT  = 4,
   parameter int unsigned OUT_W    = 3,
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rs1,
   input  logic [4:0]  iss_rs2,
   input  logic [4:0]  iss_rd,
   input  logic        iss_long,
   output logic        iss_stall,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_wR,
   output logic [31:0] rf_wD,
   output logic [31:0] sb_pending
);

   logic [31:0]       pending_q, pending_d;
   logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              drain_q, drain_d;

   logic wb_use;
   logic lu_grant;
   logic lu_fire;
   logic lu_clr;
   logic lu_dec;
   logic lu_denied;
   logic iss_raw;
   logic iss_waw;
   logic iss_full;
   logic iss_block;
   logic iss_fire;
   logic iss_set;

   // Arbitration and hazard detection
   always_comb begin
      wb_use    = wb_valid && (wb_rd != 5'd0);
      lu_grant  = !wb_use;
      lu_fire   = lu_valid && lu_grant;
      lu_clr    = lu_fire && (lu_rd != 5'd0);
      // A result for a non-pending register (e.g. one issued before a reset)
      // must not drive the counter below zero.
      lu_dec    = lu_clr && (out_cnt_q != '0);
      lu_denied = lu_valid && !lu_grant;

      iss_raw   = ((iss_rs1 != 5'd0) && pending_q[iss_rs1]) ||
                  ((iss_rs2 != 5'd0) && pending_q[iss_rs2]);
      iss_waw   = (iss_rd != 5'd0) && pending_q[iss_rd];
      iss_full  = iss_long && (out_cnt_q >= OUT_W'(MAX_OUT));
      iss_block = iss_valid && (iss_raw || iss_waw || iss_full || drain_q);
      iss_fire  = iss_valid && !iss_block;
      iss_set   = iss_fire && iss_long && (iss_rd != 5'd0);
   end

   // Next-state logic
   always_comb begin
      pending_d  = pending_q;
      out_cnt_d  = out_cnt_q;
      wait_cnt_d = '0;
      drain_d    = drain_q;

      // Clear before set; WAW stalls guarantee both never target one register.
      if (lu_clr) begin
         pending_d[lu_rd] = 1'b0;
      end
      if (iss_set) begin
         pending_d[iss_rd] = 1'b1;
      end

      unique case ({iss_set, lu_dec})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: out_cnt_d = out_cnt_q;
      endcase

      if (lu_denied) begin
         if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end

      // Drain holds off all issue until the starved result finally lands.
      if (lu_fire) begin
         drain_d = 1'b0;
      end else if (lu_denied && (wait_cnt_d == WAIT_W'(MAX_WAIT))) begin
         drain_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         out_cnt_q  <= '0;
         wait_cnt_q <= '0;
         drain_q    <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         out_cnt_q  <= out_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         drain_q    <= drain_d;
      end
   end

   // Outputs; all forced low while reset is asserted
   always_comb begin
      rf_we      = 1'b0;
      rf_wR      = 5'd0;
      rf_wD      = 32'd0;
      lu_ready   = 1'b0;
      iss_stall  = 1'b0;
      sb_pending = 32'd0;
      if (!rst) begin
         lu_ready   = lu_grant;
         iss_stall  = iss_block;
         sb_pending = pending_q;
         if (wb_use) begin
            rf_we = 1'b1;
            rf_wR = wb_rd;
            rf_wD = wb_data;
         end else if (lu_clr) begin
            rf_we = 1'b1;
            rf_wR = lu_rd;
            rf_wD = lu_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard. The driver sets inputs just after each
// rising edge and queues the hand-computed outputs for that cycle; an
// independent monitor pops one entry at each falling edge and compares.
module tb_rf_wb_scoreboard;

   logic        clk;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic [4:0]  iss_rd;
   logic        iss_long;
   logic        iss_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        rf_we;
   logic [4:0]  rf_wR;
   logic [31:0] rf_wD;
   logic [31:0] sb_pending;

   rf_wb_scoreboard #(
      .MAX_OUT  (4),
      .OUT_W    (3),
      .MAX_WAIT (8),
      .WAIT_W   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_rs1    (iss_rs1),
      .iss_rs2    (iss_rs2),
      .iss_rd     (iss_rd),
      .iss_long   (iss_long),
      .iss_stall  (iss_stall),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .lu_valid   (lu_valid),
      .lu_rd      (lu_rd),
      .lu_data    (lu_data),
      .lu_ready   (lu_ready),
      .rf_we      (rf_we),
      .rf_wR      (rf_wR),
      .rf_wD      (rf_wD),
      .sb_pending (sb_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        rdy;
      logic        stall;
      logic [31:0] pend;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Monitor: one expected entry per checked cycle, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if (rf_we === mon_e.we && rf_wR === mon_e.wr && rf_wD === mon_e.wd &&
             lu_ready === mon_e.rdy && iss_stall === mon_e.stall &&
             sb_pending === mon_e.pend) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got we=%0b wR=%0d wD=%h rdy=%0b stall=%0b pend=%h; want we=%0b wR=%0d wD=%h rdy=%0b stall=%0b pend=%h",
                     mon_e.name, rf_we, rf_wR, rf_wD, lu_ready, iss_stall, sb_pending,
                     mon_e.we, mon_e.wr, mon_e.wd, mon_e.rdy, mon_e.stall, mon_e.pend);
         end
      end
   end

   task automatic push_exp(input string nm, input logic we, input logic [4:0] wr,
                           input logic [31:0] wd, input logic rdy, input logic stall,
                           input logic [31:0] pend);
      exp_t e;
      e.name  = nm;
      e.we    = we;
      e.wr    = wr;
      e.wd    = wd;
      e.rdy   = rdy;
      e.stall = stall;
      e.pend  = pend;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic lng);
      iss_valid = v;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
      iss_rd    = rd;
      iss_long  = lng;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb_valid = v;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lu_valid = v;
      lu_rd    = rd;
      lu_data  = d;
   endtask

   task automatic idle();
      set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b0, 5'd0, 32'd0);
      set_lu(1'b0, 5'd0, 32'd0);
   endtask

   logic [31:0] ep;

   initial begin
      rst = 1'b1;
      idle();
      set_wb(1'b1, 5'd5, 32'h55);
      tick();
      push_exp("rst_wb_blocked", 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      idle();
      push_exp("idle_after_rst", 0, 0, 0, 1, 0, 0);
      tick();
      set_wb(1'b1, 5'd5, 32'h55);
      push_exp("wb_basic", 1, 5, 32'h55, 0, 0, 0);
      tick();

      // Long issue to x7, dependent stalls until the x7 result is written
      idle();
      set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
      push_exp("iss_long_x7", 0, 0, 0, 1, 0, 0);
      tick();
      set_iss(1'b1, 5'd7, 5'd0, 5'd8, 1'b0);
      push_exp("raw_x7_stall", 0, 0, 0, 1, 1, 32'h80);
      tick();
      push_exp("raw_x7_hold", 0, 0, 0, 1, 1, 32'h80);
      tick();
      set_lu(1'b1, 5'd7, 32'hDEADBEEF);
      push_exp("lu_fire_x7", 1, 7, 32'hDEADBEEF, 1, 1, 32'h80);
      tick();
      set_lu(1'b0, 5'd0, 32'd0);
      push_exp("raw_x7_release", 0, 0, 0, 1, 0, 0);
      tick();

      // Port conflict: pipeline wins, long unit goes next cycle
      idle();
      set_wb(1'b1, 5'd3, 32'h11);
      set_lu(1'b1, 5'd4, 32'h22);
      push_exp("conflict_wb_wins", 1, 3, 32'h11, 0, 0, 0);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      push_exp("conflict_lu_next", 1, 4, 32'h22, 1, 0, 0);
      tick();
      set_wb(1'b1, 5'd0, 32'h99);
      set_lu(1'b1, 5'd9, 32'h33);
      push_exp("wb_x0_lu_granted", 1, 9, 32'h33, 1, 0, 0);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      set_lu(1'b1, 5'd0, 32'h44);
      push_exp("lu_x0_no_write", 0, 0, 0, 1, 0, 0);
      tick();

      // Fill to the outstanding limit with x1..x4
      idle();
      ep = 32'd0;
      for (int i = 1; i <= 4; i++) begin
         set_iss(1'b1, 5'd0, 5'd0, 5'(i), 1'b1);
         push_exp("fill", 0, 0, 0, 1, 0, ep);
         ep[i] = 1'b1;
         tick();
      end
      set_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
      push_exp("full_stall", 0, 0, 0, 1, 1, 32'h1E);
      tick();
      set_lu(1'b1, 5'd2, 32'h2222);
      push_exp("full_lu_x2", 1, 2, 32'h2222, 1, 1, 32'h1E);
      tick();
      set_lu(1'b0, 5'd0, 32'd0);
      push_exp("full_release", 0, 0, 0, 1, 0, 32'h1A);
      tick();
      set_iss(1'b1, 5'd11, 5'd12, 5'd10, 1'b0);
      push_exp("full_nonlong_ok", 0, 0, 0, 1, 0, 32'h3A);
      tick();
      set_iss(1'b1, 5'd0, 5'd0, 5'd3, 1'b0);
      push_exp("waw_x3", 0, 0, 0, 1, 1, 32'h3A);
      tick();
      set_iss(1'b1, 5'd0, 5'd5, 5'd20, 1'b0);
      push_exp("raw_rs2_x5", 0, 0, 0, 1, 1, 32'h3A);
      tick();

      // Starvation: long unit denied for 10 cycles, drain after the 8th
      set_iss(1'b1, 5'd21, 5'd22, 5'd20, 1'b0);
      set_wb(1'b1, 5'd6, 32'h66);
      set_lu(1'b1, 5'd1, 32'h1111);
      for (int i = 1; i <= 10; i++) begin
         push_exp("starve", 1, 6, 32'h66, 0, (i >= 9), 32'h3A);
         tick();
      end
      set_wb(1'b0, 5'd0, 32'd0);
      push_exp("drain_lu_fire", 1, 1, 32'h1111, 1, 1, 32'h3A);
      tick();
      set_lu(1'b0, 5'd0, 32'd0);
      push_exp("drain_cleared", 0, 0, 0, 1, 0, 32'h38);
      tick();

      // Asynchronous reset pulse that spans no rising edge
      idle();
      rst = 1'b1;
      push_exp("rst_async", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      tick();
      set_lu(1'b1, 5'd3, 32'h3333);
      push_exp("post_rst_lu_write", 1, 3, 32'h3333, 1, 0, 0);
      tick();
      set_lu(1'b0, 5'd0, 32'd0);
      ep = 32'd0;
      for (int i = 9; i <= 12; i++) begin
         set_iss(1'b1, 5'd0, 5'd0, 5'(i), 1'b1);
         push_exp("post_rst_fill", 0, 0, 0, 1, 0, ep);
         ep[i] = 1'b1;
         tick();
      end
      set_iss(1'b1, 5'd0, 5'd0, 5'd13, 1'b1);
      push_exp("post_rst_full", 0, 0, 0, 1, 1, 32'h1E00);
      tick();
      idle();

      @(negedge clk);
      #1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Write-port arbiter and hazard scoreboard for the 32x32 register file (2 async read ports, 1 sync write port, x0 hard-wired zero).
- Shares the single RF write port between the pipeline writeback path and a multi-cycle long-latency unit (load/MDU) using a valid/ready handshake.
- Tracks registers with outstanding long-unit writes and stalls issue on RAW/WAW hazards and on outstanding-limit overflow.
- Forces a pipeline drain when the long unit is starved of the write port.

Parameters:
- MAX_OUT, 4: maximum outstanding long-unit writes (1..2^OUT_W-1).
- OUT_W, 3: width of the outstanding counter.
- MAX_WAIT, 8: consecutive denied long-unit cycles before drain is forced (>=1).
- WAIT_W, 4: width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  instruction presented at issue.
- iss_rs1  in  5  source register 1.
- iss_rs2  in  5  source register 2.
- iss_rd  in  5  destination register.
- iss_long  in  1  destination is written by the long unit.
- iss_stall  out  1  issue blocked this cycle.
- wb_valid  in  1  pipeline writeback valid; cannot be back-pressured.
- wb_rd  in  5  pipeline writeback destination.
- wb_data  in  32  pipeline writeback data.
- lu_valid  in  1  long-unit result valid.
- lu_rd  in  5  long-unit destination.
- lu_data  in  32  long-unit data.
- lu_ready  out  1  long-unit result accepted this cycle.
- rf_we  out  1  RF write enable.
- rf_wR  out  5  RF write address.
- rf_wD  out  32  RF write data.
- sb_pending  out  32  scoreboard vector; bit i = xi write outstanding.

Behaviour:
- Reset (async, immediate):
  - pending=0, out_cnt=0, wait_cnt=0, drain=0.
  - While rst is high, all combinational outputs are forced: rf_we=0, rf_wR=0, rf_wD=0, lu_ready=0, iss_stall=0, sb_pending=0.
- Port use:
  - wb_use = wb_valid && wb_rd!=0.
  - Writebacks to x0 do not occupy the write port.
- Arbitration (combinational, zero latency):
  - The pipeline has priority.
  - lu_ready = !wb_use.
  - lu_fire = lu_valid && lu_ready.
- RF write mux:
  - If wb_use: rf_we=1, rf_wR=wb_rd, rf_wD=wb_data.
  - Else if lu_fire && lu_rd!=0: rf_we=1, rf_wR=lu_rd, rf_wD=lu_data.
  - Else rf_we=0, rf_wR=0, rf_wD=0.
- Long-unit handshake:
  - lu_rd/lu_data must stay stable while lu_valid && !lu_ready.
  - lu_fire with lu_rd=0 is accepted and consumes no write.
- Hazard stall (combinational):
  - raw = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]).
  - waw = (rd!=0 && pending[rd]).
  - full = iss_long && out_cnt==MAX_OUT.
  - iss_stall = iss_valid && (raw || waw || full || drain).
- Issue accept:
  - iss_fire = iss_valid && !iss_stall.
  - iss_set = iss_fire && iss_long && iss_rd!=0.
  - iss_long with rd=0 sets no pending bit and does not count.
- Scoreboard update (posedge):
  - If lu_fire && lu_rd!=0, clear pending[lu_rd].
  - Then, if iss_set, set pending[iss_rd]. Set is applied after clear.
  - The same register cannot be both cleared and set in one cycle, because waw uses pre-update pending.
  - A pending bit clears only on its own lu_fire. The RF write and the clear land on the same edge, so dependents issue the cycle after.
- out_cnt update:
  - Add 1 on iss_set; subtract 1 on lu_fire && lu_rd!=0. Both in one cycle: unchanged.
  - Never exceeds MAX_OUT; never underflows.
  - A lu_fire for a register that is not pending is a protocol error: scoreboard unchanged, out_cnt saturates at 0.
- Starvation and drain:
  - wait_cnt increments (saturating at MAX_WAIT) each cycle lu_valid && !lu_ready.
  - wait_cnt resets to 0 on lu_fire or when !lu_valid.
  - drain sets on the edge where wait_cnt reaches MAX_WAIT; it then stalls all issue, so bubbles reach wb.
  - drain clears on the edge of the next lu_fire.
- Reset mid-operation:
  - All pending entries are discarded.
  - Long-unit results arriving after reset are still written if granted; out_cnt stays at 0 (saturate).
- sb_pending = pending register, direct output. Bit 0 is always 0.

Test Plan:
- Reset then idle: rst pulse with wb_valid=1, wb_rd=5 held -> rf_we=0 during rst; all outputs and sb_pending=0 after.
- Long issue rd=7, then rs1=7 on the next cycle -> sb_pending=0x80; iss_stall=1 until the lu_fire edge for rd=7 with lu_data=0xDEADBEEF; iss_stall=0 the following cycle; rf_wD=0xDEADBEEF on the fire cycle.
- Conflict: wb_valid rd=3 data=0x11 and lu_valid rd=4 data=0x22 in the same cycle -> rf_wR=3, lu_ready=0. Next cycle with wb_valid=0 -> rf_wR=4, rf_wD=0x22.
- wb_rd=0 with lu_valid rd=9 -> lu_ready=1, rf_wR=9. lu_valid with rd=0 -> lu_ready=1, rf_we=0, no scoreboard change.
- Four long issues rd=1..4 (MAX_OUT=4); fifth long issue rd=5 -> iss_stall=1 while out_cnt=4. Completing rd=2 -> fifth accepted next cycle; sb_pending=0x3A.
- Starvation: wb_valid rd=6 held 10 cycles with lu_valid -> drain asserts after 8 denied cycles; iss_stall=1 for a non-hazard issue. Drop wb_valid -> lu_fire and drain clears next edge.
